// File: rtl/seq_scan_ctrl.sv
// Sequencing controller for a bit-serial 1101 Mealy detector.
// Takes a word, clears the detector, shifts the word MSB-first and returns match stats.
module seq_scan_ctrl #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH + 1),
   parameter int POS_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             det_rst,
   output logic             det_in,
   input  logic             det_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] match_cnt,
   output logic             match_any,
   output logic [POS_W-1:0] first_pos,
   output logic             busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CLEAR = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [POS_W-1:0] LAST = POS_W'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [POS_W-1:0] k_q, k_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic             any_q, any_d;
   logic             det_in_q, det_in_d;
   logic             det_rst_q, det_rst_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      k_d       = k_q;
      cnt_d     = cnt_q;
      pos_d     = pos_q;
      any_d     = any_q;
      det_in_d  = 1'b0;
      det_rst_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               word_d    = in_data;
               cnt_d     = '0;
               pos_d     = '0;
               any_d     = 1'b0;
               det_rst_d = 1'b1;
               state_d   = CLEAR;
            end
         end
         CLEAR: begin
            // det_in is registered, so the MSB is launched on the edge leaving CLEAR
            k_d      = '0;
            det_in_d = word_q[WIDTH-1];
            word_d   = {word_q[WIDTH-2:0], 1'b0};
            state_d  = SHIFT;
         end
         SHIFT: begin
            if (det_y) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (!any_q) begin
                  pos_d = k_q;
                  any_d = 1'b1;
               end
            end
            if (k_q == LAST) begin
               state_d = DONE;
            end else begin
               k_d      = k_q + POS_W'(1);
               det_in_d = word_q[WIDTH-1];
               word_d   = {word_q[WIDTH-2:0], 1'b0};
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         word_q      <= '0;
         k_q         <= '0;
         cnt_q       <= '0;
         pos_q       <= '0;
         any_q       <= 1'b0;
         det_in_q    <= 1'b0;
         det_rst_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         k_q         <= k_d;
         cnt_q       <= cnt_d;
         pos_q       <= pos_d;
         any_q       <= any_d;
         det_in_q    <= det_in_d;
         det_rst_q   <= det_rst_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign det_rst   = det_rst_q;
   assign det_in    = det_in_q;
   assign out_valid = out_valid_q;
   assign match_cnt = cnt_q;
   assign match_any = any_q;
   assign first_pos = pos_q;
   assign busy      = busy_q;

endmodule
